lzc_arb_ctrl: RTL and testbench
===============================

LZC_ARB_CTRL -- requirements
Module: lzc_arb_ctrl

Interface
REQ-001 The block SHALL have parameter RR_EN, default 1, selecting arbitration: 1 = round-robin, 0 = fixed priority with port 0 highest.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have ports req0_valid and req1_valid, input, 1 bit each: the requester has an operand pending.
REQ-005 The block SHALL have ports req0_ready and req1_ready, output, 1 bit each: the operand is accepted this cycle.
REQ-006 The block SHALL have ports req0_data and req1_data, input, 64 bits each: the operand to count.
REQ-007 The block SHALL have ports req0_w64 and req1_w64, input, 1 bit each: 1 = count all 64 bits, 0 = count bits [31:0] only.
REQ-008 The block SHALL have port lzc_in, output, 32 bits: the word driven to the shared external 32-bit leading-zero counter.
REQ-009 The block SHALL have port lzc_cnt, input, 6 bits: the combinational same-cycle count from the shared counter, valid range 0..32.
REQ-010 The block SHALL have port rsp_valid, output, 1 bit: a result is available.
REQ-011 The block SHALL have port rsp_ready, input, 1 bit: the consumer accepts the result.
REQ-012 The block SHALL have port rsp_id, output, 1 bit: the index of the requester that owns the result.
REQ-013 The block SHALL have port rsp_cnt, output, 7 bits: the leading-zero count, range 0..64.
REQ-014 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-015 The FSM SHALL have the states IDLE, HI, LO and RESP.
REQ-016 In IDLE, when any reqN_valid is high, the block SHALL grant exactly one port: it asserts that port's reqN_ready for one cycle and latches its data, w64 flag and id.
REQ-017 req0_ready and req1_ready SHALL be 0 in every state other than IDLE, and SHALL never both be 1 in the same cycle.
REQ-018 Arbitration with RR_EN=1: when both ports are valid, the port indicated by the round-robin pointer wins; the pointer SHALL update to the non-granted port when the response is accepted.
REQ-019 Arbitration with RR_EN=0: port 0 SHALL always win a tie.
REQ-020 IDLE state transitions: on a grant, the next state SHALL be HI if the latched w64 = 1, and LO otherwise.
REQ-021 HI state: the block SHALL drive lzc_in = data[63:32].
REQ-022 In HI, if lzc_cnt < 32, the block SHALL set result = lzc_cnt and go to RESP; otherwise it SHALL set partial = 32 and go to LO.
REQ-023 LO state: the block SHALL drive lzc_in = data[31:0], set result = partial + lzc_cnt (partial is 0 when HI was skipped), and go to RESP.
REQ-024 Any lzc_cnt value greater than 32 SHALL be treated as 32.
REQ-025 RESP state: rsp_valid = 1, and rsp_cnt and rsp_id SHALL stay stable until the rsp_valid && rsp_ready handshake.
REQ-026 On the RESP handshake, the FSM SHALL return to IDLE; a new grant SHALL occur no earlier than the following cycle.
REQ-027 lzc_in SHALL be 0 in IDLE and RESP.
REQ-028 Latency, with grant at cycle T: a 32-bit request SHALL raise rsp_valid at T+2.
REQ-029 Latency, with grant at cycle T: a 64-bit request with a nonzero upper half SHALL raise rsp_valid at T+2.
REQ-030 Latency, with grant at cycle T: a 64-bit request with a zero upper half SHALL raise rsp_valid at T+3.
REQ-031 A requester that drops valid before being granted SHALL lose no state; no grant SHALL occur for it.

Reset
REQ-032 While rst_n = 0, the outputs SHALL be: state IDLE, round-robin pointer 0, req0_ready = req1_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_cnt = 0, lzc_in = 0, busy = 0.
REQ-033 Reset asserted mid-operation (in HI, LO or RESP) SHALL abort the operation with no response produced.
REQ-034 The first grant after reset release SHALL occur no earlier than the first rising clk edge with rst_n = 1.

Verification
REQ-035 Scenario: port 0, w64=0, data=0x0000_0000_0001_0000 -> rsp_cnt=15, rsp_id=0, rsp_valid at T+2.
REQ-036 Scenario: port 1, w64=1, data=0x0000_0000_0000_0001 -> HI then LO visited, rsp_cnt=63, rsp_valid at T+3.
REQ-037 Scenario: w64=1, data=0 -> rsp_cnt=64; and w64=0, data=0xFFFF_FFFF_0000_0000 -> rsp_cnt=32.
REQ-038 Scenario: RR_EN=1 with both ports continuously valid -> grants alternate 0,1,0,1; with RR_EN=0 -> port 0 is always granted.
REQ-039 Scenario: rsp_ready held low for 5 cycles -> rsp_cnt and rsp_id stay stable, no ready asserted, busy=1 throughout.
REQ-040 Scenario: rst_n pulsed low while in LO -> all outputs go to reset values immediately, and no response appears after release.

Source files
------------

// File: rtl/lzc_arb_ctrl.sv
// Two-port arbiter sharing one external 32-bit leading-zero counter.
// A 64-bit operand takes one or two passes, depending on whether its upper half is zero.
module lzc_arb_ctrl #(
   parameter int unsigned RR_EN = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   input  logic        req1_valid,
   output logic        req0_ready,
   output logic        req1_ready,
   input  logic [63:0] req0_data,
   input  logic [63:0] req1_data,
   input  logic        req0_w64,
   input  logic        req1_w64,
   output logic [31:0] lzc_in,
   input  logic [5:0]  lzc_cnt,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [6:0]  rsp_cnt,
   output logic        busy
);

   localparam int unsigned DW   = 64;
   localparam int unsigned HW   = 32;
   localparam int unsigned CW   = 6;
   localparam int unsigned RW   = 7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HI   = 2'd1,
      LO   = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t        state;
   logic          armed;
   logic          rr_ptr;
   logic [HW-1:0] lo_q;
   logic [RW-1:0] partial;

   logic          gnt_any;
   logic          gnt_id;
   logic [DW-1:0] sel_data;
   logic          sel_w64;
   logic [CW-1:0] cnt_sat;

   // Grant selection: a tie goes to the pointer (round-robin) or to port 0 (fixed).
   always_comb begin
      gnt_id = 1'b0;
      if (req0_valid && req1_valid) begin
         gnt_id = (RR_EN != 0) ? rr_ptr : 1'b0;
      end else begin
         gnt_id = !req0_valid;
      end
      gnt_any  = armed && (state == IDLE) && (req0_valid || req1_valid);
      sel_data = gnt_id ? req1_data : req0_data;
      sel_w64  = gnt_id ? req1_w64 : req0_w64;
      cnt_sat  = (lzc_cnt > CW'(HW)) ? CW'(HW) : lzc_cnt;
   end

   // Ready acknowledges the current-cycle valid, so a request withdrawn before the grant is never taken.
   assign req0_ready = gnt_any && !gnt_id;
   assign req1_ready = gnt_any && gnt_id;

   // armed holds off any grant until the first clock edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         armed     <= 1'b0;
         rr_ptr    <= 1'b0;
         lo_q      <= '0;
         partial   <= '0;
         lzc_in    <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_cnt   <= '0;
         busy      <= 1'b0;
      end else begin
         armed <= 1'b1;
         case (state)
            IDLE: begin
               if (gnt_any) begin
                  lo_q    <= sel_data[HW-1:0];
                  rsp_id  <= gnt_id;
                  partial <= '0;
                  busy    <= 1'b1;
                  if (sel_w64) begin
                     state  <= HI;
                     lzc_in <= sel_data[DW-1:HW];
                  end else begin
                     state  <= LO;
                     lzc_in <= sel_data[HW-1:0];
                  end
               end
            end
            HI: begin
               if (cnt_sat < CW'(HW)) begin
                  rsp_cnt   <= RW'(cnt_sat);
                  rsp_valid <= 1'b1;
                  lzc_in    <= '0;
                  state     <= RESP;
               end else begin
                  partial <= RW'(HW);
                  lzc_in  <= lo_q;
                  state   <= LO;
               end
            end
            LO: begin
               rsp_cnt   <= partial + RW'(cnt_sat);
               rsp_valid <= 1'b1;
               lzc_in    <= '0;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
                  if (RR_EN != 0) begin
                     rr_ptr <= !rsp_id;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lzc_arb_ctrl.sv
// Bench for lzc_arb_ctrl: one round-robin and one fixed-priority instance on shared stimulus,
// each checked every cycle against a transaction-level model, plus literal scenario results.
module tb_lzc_arb_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        v0, v1, w0, w1, rsp_rdy, over;
   logic [63:0] d0, d1;

   logic        rdy0 [2];
   logic        rdy1 [2];
   logic        rv   [2];
   logic        rid  [2];
   logic        bsy  [2];
   logic [31:0] lin  [2];
   logic [5:0]  lcnt [2];
   logic [6:0]  rcnt [2];

   int checks = 0;
   int failures = 0;
   int cyc_n = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   // External shared counter; with 'over' set it reports an out-of-range value for zero input.
   function automatic logic [5:0] ext_lzc(input logic [31:0] x, input logic ovr);
      if (x == 32'd0) return ovr ? 6'd45 : 6'd32;
      for (int b = 31; b >= 0; b--) if (x[b]) return 6'(31 - b);
      return 6'd32;
   endfunction

   assign lcnt[0] = ext_lzc(lin[0], over);
   assign lcnt[1] = ext_lzc(lin[1], over);

   lzc_arb_ctrl #(.RR_EN(1)) u_rr (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(v0), .req1_valid(v1), .req0_ready(rdy0[0]), .req1_ready(rdy1[0]),
      .req0_data(d0), .req1_data(d1), .req0_w64(w0), .req1_w64(w1),
      .lzc_in(lin[0]), .lzc_cnt(lcnt[0]),
      .rsp_valid(rv[0]), .rsp_ready(rsp_rdy), .rsp_id(rid[0]), .rsp_cnt(rcnt[0]), .busy(bsy[0])
   );

   lzc_arb_ctrl #(.RR_EN(0)) u_fp (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(v0), .req1_valid(v1), .req0_ready(rdy0[1]), .req1_ready(rdy1[1]),
      .req0_data(d0), .req1_data(d1), .req0_w64(w0), .req1_w64(w1),
      .lzc_in(lin[1]), .lzc_cnt(lcnt[1]),
      .rsp_valid(rv[1]), .rsp_ready(rsp_rdy), .rsp_id(rid[1]), .rsp_cnt(rcnt[1]), .busy(bsy[1])
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference leading-zero count over the selected width.
   function automatic int model_clz(input logic [63:0] d, input logic w);
      int n;
      n = w ? 64 : 32;
      for (int b = n - 1; b >= 0; b--) if (d[b]) return n - 1 - b;
      return n;
   endfunction

   // Transaction model: phase 0 = free, 1 = computing, 2 = response pending.
   int          m_ph [2];
   int          m_k  [2];
   int          m_lat[2];
   int          m_cnt[2];
   logic        m_arm[2];
   logic        m_ptr[2];
   logic        m_id [2];
   logic        m_w  [2];
   logic [63:0] m_d  [2];

   task automatic model_step(input int i);
      logic        rr;
      logic        e0, e1, erv, eb, win;
      logic [31:0] el;
      string       p;
      rr = (i == 0);
      e0 = 1'b0; e1 = 1'b0; erv = 1'b0; eb = 1'b0; el = '0;
      p = $sformatf("dut%0d", i);
      if (!rst_n) begin
         m_ph[i] = 0; m_arm[i] = 1'b0; m_ptr[i] = 1'b0;
         chk({p, " rst rsp_id"}, rid[i], 0);
         chk({p, " rst rsp_cnt"}, rcnt[i], 0);
      end else begin
         case (m_ph[i])
            0: begin
               if (m_arm[i] && (v0 || v1)) begin
                  win = (v0 && v1) ? (rr ? m_ptr[i] : 1'b0) : !v0;
                  e0 = !win; e1 = win;
                  m_id[i]  = win;
                  m_d[i]   = win ? d1 : d0;
                  m_w[i]   = win ? w1 : w0;
                  m_cnt[i] = model_clz(m_d[i], m_w[i]);
                  m_lat[i] = (m_w[i] && m_d[i][63:32] == 32'd0) ? 3 : 2;
                  m_k[i]   = 1;
                  m_ph[i]  = 1;
               end
               m_arm[i] = 1'b1;
            end
            1: begin
               eb = 1'b1;
               el = (m_k[i] == 1 && m_w[i]) ? m_d[i][63:32] : m_d[i][31:0];
               if (m_k[i] == m_lat[i] - 1) m_ph[i] = 2;
               else m_k[i]++;
            end
            default: begin
               erv = 1'b1; eb = 1'b1;
               chk({p, " rsp_id"}, rid[i], m_id[i]);
               chk({p, " rsp_cnt"}, rcnt[i], m_cnt[i]);
               if (rsp_rdy) begin
                  m_ph[i] = 0;
                  if (rr) m_ptr[i] = !m_id[i];
               end
            end
         endcase
      end
      chk({p, " req0_ready"}, rdy0[i], e0);
      chk({p, " req1_ready"}, rdy1[i], e1);
      chk({p, " rsp_valid"}, rv[i], erv);
      chk({p, " busy"}, bsy[i], eb);
      chk({p, " lzc_in"}, lin[i], el);
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) model_step(i);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One request on port p with rsp_ready high; checks literal count, owner and latency on the RR instance.
   task automatic do_req(input logic p, input logic [63:0] d, input logic w,
                         input int exp_cnt, input int exp_lat, input string nm);
      int         t0, lat;
      logic [6:0] c;
      logic       id;
      t0 = -1; lat = -1; c = '0; id = 1'b0;
      if (p) begin v1 = 1'b1; d1 = d; w1 = w; end
      else   begin v0 = 1'b1; d0 = d; w0 = w; end
      for (int n = 0; n < 10 && t0 < 0; n++) begin
         @(negedge clk);
         if (p ? rdy1[0] : rdy0[0]) t0 = cyc_n;
      end
      tick();
      v0 = 1'b0; v1 = 1'b0;
      for (int n = 0; n < 10 && lat < 0; n++) begin
         @(negedge clk);
         if (rv[0]) begin lat = cyc_n - t0; c = rcnt[0]; id = rid[0]; end
      end
      chk({nm, " cnt"}, c, exp_cnt);
      chk({nm, " id"}, id, p);
      chk({nm, " latency"}, lat, exp_lat);
      tick();
   endtask

   logic [3:0] exp_rr;
   logic       g_rr [4];
   logic       g_fp [4];

   initial begin
      int n_rr, n_fp, seen, t_rel, t_g;
      v0 = 0; v1 = 0; w0 = 0; w1 = 0; d0 = '0; d1 = '0; rsp_rdy = 1'b1; over = 1'b0;
      exp_rr = 4'b1010;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset rsp_valid", rv[0], 0);
      chk("reset busy", bsy[0], 0);
      chk("reset lzc_in", lin[0], 0);
      tick();
      rst_n = 1'b1;
      tick();

      // Both ports continuously valid right after reset: RR alternates, fixed priority keeps port 0.
      v0 = 1; d0 = 64'h0000_0000_0001_0000; w0 = 0;
      v1 = 1; d1 = 64'h0000_0000_0000_0100; w1 = 0;
      n_rr = 0; n_fp = 0;
      for (int n = 0; n < 40 && (n_rr < 4 || n_fp < 4); n++) begin
         @(negedge clk);
         if ((rdy0[0] || rdy1[0]) && n_rr < 4) begin g_rr[n_rr] = rdy1[0]; n_rr++; end
         if ((rdy0[1] || rdy1[1]) && n_fp < 4) begin g_fp[n_fp] = rdy1[1]; n_fp++; end
      end
      tick();
      v0 = 0; v1 = 0;
      chk("rr grant count", n_rr, 4);
      chk("fp grant count", n_fp, 4);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("rr grant %0d", k), g_rr[k], exp_rr[k]);
         chk($sformatf("fp grant %0d", k), g_fp[k], 0);
      end
      repeat (6) tick();

      do_req(1'b0, 64'h0000_0000_0001_0000, 1'b0, 15, 2, "p0 w32");
      do_req(1'b1, 64'h0000_0000_0000_0001, 1'b1, 63, 3, "p1 w64 lo");
      do_req(1'b0, 64'h0000_0000_0000_0000, 1'b1, 64, 3, "w64 zero");
      do_req(1'b1, 64'hFFFF_FFFF_0000_0000, 1'b0, 32, 2, "w32 upper only");
      do_req(1'b0, 64'h0000_8000_0000_0000, 1'b1, 16, 2, "w64 hi");
      do_req(1'b1, 64'h8000_0000_0000_0000, 1'b1, 0, 2, "w64 msb");
      do_req(1'b0, 64'h0000_0000_0000_00FF, 1'b1, 56, 3, "w64 lo byte");
      over = 1'b1;
      do_req(1'b0, 64'h0000_0000_0000_0000, 1'b0, 32, 2, "sat w32");
      do_req(1'b1, 64'h0000_0000_0000_0000, 1'b1, 64, 3, "sat w64");
      over = 1'b0;

      // Backpressure; port 0 is valid during the stall and withdraws before the block is free.
      rsp_rdy = 1'b0;
      v1 = 1; d1 = 64'h0000_0000_0000_0F00; w1 = 0;
      seen = 0;
      for (int n = 0; n < 10 && seen == 0; n++) begin @(negedge clk); if (rdy1[0]) seen = 1; end
      tick();
      v1 = 0; v0 = 1; d0 = 64'h1; w0 = 0;
      seen = 0;
      for (int n = 0; n < 10 && seen == 0; n++) begin @(negedge clk); if (rv[0]) seen = 1; end
      chk("stall rsp seen", seen, 1);
      for (int k = 0; k < 5; k++) begin
         tick();
         @(negedge clk);
         chk("stall rsp_cnt", rcnt[0], 20);
         chk("stall rsp_id", rid[0], 1);
         chk("stall busy", bsy[0], 1);
         chk("stall ready0", rdy0[0], 0);
      end
      tick();
      v0 = 0; rsp_rdy = 1'b1;
      seen = 0;
      for (int k = 0; k < 4; k++) begin tick(); @(negedge clk); if (rdy0[0] || rdy0[1]) seen++; end
      chk("withdrawn no grant", seen, 0);

      // Reset while in LO aborts the operation; a request waiting through reset is granted afterwards.
      v0 = 1; d0 = 64'h0000_0000_0000_0001; w0 = 1;
      seen = 0;
      for (int n = 0; n < 10 && seen == 0; n++) begin @(negedge clk); if (rdy0[0]) seen = 1; end
      tick();
      v0 = 0;
      tick();
      rst_n = 1'b0;
      #1;
      chk("abort rsp_valid", rv[0], 0);
      chk("abort busy", bsy[0], 0);
      chk("abort lzc_in", lin[0], 0);
      chk("abort rsp_cnt", rcnt[0], 0);
      chk("abort rsp_id", rid[0], 0);
      chk("abort fp busy", bsy[1], 0);
      v0 = 1; d0 = 64'h0000_0000_0000_00FF; w0 = 0;
      @(negedge clk);
      chk("ready in reset", rdy0[0], 0);
      tick();
      tick();
      rst_n = 1'b1;
      t_rel = cyc_n;
      t_g = -1;
      for (int n = 0; n < 10 && t_g < 0; n++) begin @(negedge clk); if (rdy0[0]) t_g = cyc_n; end
      chk("first grant after release", t_g - t_rel, 1);
      tick();
      v0 = 0;
      seen = 0;
      for (int n = 0; n < 6; n++) begin @(negedge clk); if (rv[0]) begin seen++; chk("post-reset cnt", rcnt[0], 24); end tick(); end
      chk("post-reset rsp count", seen, 1);
      repeat (4) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
